// File: rtl/addsub_pkg.sv
// addsub_pkg: shared constants and helpers for the pipelined adder/subtractor.
// Mode encoding, stage count and configuration check used by addsub_pipe.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int stages_of(
    input int width,
    input int chunk
  );
    return width / chunk;
  endfunction

  function automatic bit cfg_ok(
    input int width,
    input int chunk
  );
    return (width >= 2) && (chunk >= 1) &&
           ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: CHUNK-bit carry-lookahead adder slice, purely combinational.
// Exposes the carry into its top bit so the last slice can form ov_flag.
module addsub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  // flat generate/propagate lookahead: each carry is its own sum of products
  always_comb begin
    logic cc;
    logic pp;
    cc = 1'b0;
    pp = 1'b1;
    g = x & y;
    p = x ^ y;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      cc = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = cc | (pp & cin);
    end
  end

  assign sum      = p ^ c[CHUNK-1:0];
  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: WIDTH-bit add/sub, one CHUNK-bit carry slice per stage, valid/ready.
// Define ADDSUB_PIPE_SATURATE_EN to clamp w to the signed extreme on overflow.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] w,
  output logic             c_out,
  output logic             ov_flag
);

  localparam int STAGES = stages_of(WIDTH, CHUNK);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  logic              adv;
  logic              sub;
  logic [WIDTH-1:0]  b_x;
  logic [STAGES-1:0] v_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign sub      = (m == MODE_SUB);
  assign b_x      = b ^ {WIDTH{sub}};

  // stage-valid chain; the whole pipe moves together on adv
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else if (adv) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int IW = WIDTH - LO;

    logic [IW-1:0]       a_in;
    logic [IW-1:0]       b_in;
    logic [LO+CHUNK-1:0] res_n;
    logic                cin;
    logic [CHUNK-1:0]    sum;
    logic                cout;
    logic                cm;

    if (k == 0) begin : g_src
      assign a_in  = a;
      assign b_in  = b_x;
      assign cin   = sub;
      assign res_n = sum;
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_mid.a_q;
      assign b_in  = g_stage[k-1].g_mid.b_q;
      assign cin   = g_stage[k-1].g_mid.c_q;
      assign res_n = {sum, g_stage[k-1].g_mid.res_q};
    end

    addsub_slice #(
      .CHUNK(CHUNK)
    ) u_slice (
      .x        (a_in[CHUNK-1:0]),
      .y        (b_in[CHUNK-1:0]),
      .cin      (cin),
      .sum      (sum),
      .cout     (cout),
      .c_msb_in (cm)
    );

    if (k < STAGES - 1) begin : g_mid
      logic [IW-CHUNK-1:0] a_q;
      logic [IW-CHUNK-1:0] b_q;
      logic [LO+CHUNK-1:0] res_q;
      logic                c_q;

      // resolved low result bits plus skewed upper operands
      always_ff @(posedge clk) begin
        if (adv) begin
          a_q   <= a_in[IW-1:CHUNK];
          b_q   <= b_in[IW-1:CHUNK];
          res_q <= res_n;
          c_q   <= cout;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] w_n;
      logic             ov_n;
      logic [WIDTH-1:0] w_q;
      logic             c_q;
      logic             ov_q;

      // final result, clamped on overflow when saturation is built in
      always_comb begin
        ov_n = cout ^ cm;
        w_n  = res_n;
`ifdef ADDSUB_PIPE_SATURATE_EN
        if (ov_n) begin
          w_n = {a_in[CHUNK-1], {(WIDTH-1){~a_in[CHUNK-1]}}};
        end
`else
`endif
      end

      // output register; cleared so no stale result survives a reset
      always_ff @(posedge clk) begin
        if (rst) begin
          w_q  <= '0;
          c_q  <= 1'b0;
          ov_q <= 1'b0;
        end else if (adv) begin
          w_q  <= w_n;
          c_q  <= cout;
          ov_q <= ov_n;
        end
      end
    end
  end

  assign w       = g_stage[STAGES-1].g_last.w_q;
  assign c_out   = g_stage[STAGES-1].g_last.c_q;
  assign ov_flag = g_stage[STAGES-1].g_last.ov_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: table vectors and directed sequences on a 16/4 pipe,
// plus random scoreboard sweeps on 8/2, 8/8 and 32/4 instances.
module tb_addsub_pipe;

  typedef struct packed {
    logic [15:0] w;
    logic        c;
    logic        ov;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic [15:0] w_wrap;
    logic [15:0] w_sat;
    logic        c;
    logic        ov;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        m;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] w;
  logic        c_out;
  logic        ov_flag;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   pop_cnt = 0;
  int   first_pop = 0;
  int   last_pop = 0;
  int   stall_seen = 0;
  int   sw_done = 0;
  exp_t q[$];
  vec_t tbl[12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  addsub_pipe #(
    .WIDTH(16),
    .CHUNK(4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .w         (w),
    .c_out     (c_out),
    .ov_flag   (ov_flag)
  );

  function automatic exp_t exp_of(input vec_t v);
    exp_t e;
`ifdef ADDSUB_PIPE_SATURATE_EN
    e.w = v.w_sat;
`else
    e.w = v.w_wrap;
`endif
    e.c  = v.c;
    e.ov = v.ov;
    return e;
  endfunction

  task automatic check(input bit ok, input string name,
                       input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL stale: unexpected result w=%h c=%b ov=%b",
               w, c_out, ov_flag);
    end else begin
      e = q.pop_front();
      if (w !== e.w || c_out !== e.c || ov_flag !== e.ov) begin
        n_bad++;
        $display("FAIL result: got w=%h c=%b ov=%b, want w=%h c=%b ov=%b",
                 w, c_out, ov_flag, e.w, e.c, e.ov);
      end
    end
    if (pop_cnt == 0) first_pop = cyc;
    last_pop = cyc;
    pop_cnt++;
  endtask

  task automatic step(input logic iv, input vec_t v, input logic ordy,
                      input logic chk_stall,
                      output logic popped, output logic accepted);
    @(negedge clk);
    in_valid  = iv;
    a         = v.a;
    b         = v.b;
    m         = v.m;
    out_ready = ordy;
    #1;
    cyc++;
    if (chk_stall && out_valid) begin
      stall_seen++;
      n_cmp++;
      if (in_ready !== 1'b0 || q.size() == 0) begin
        n_bad++;
        $display("FAIL stall_ready: in_ready=%b pending=%0d",
                 in_ready, q.size());
      end else if (w !== q[0].w || c_out !== q[0].c ||
                   ov_flag !== q[0].ov) begin
        n_bad++;
        $display("FAIL stall_hold: got w=%h c=%b ov=%b, want w=%h c=%b ov=%b",
                 w, c_out, ov_flag, q[0].w, q[0].c, q[0].ov);
      end
    end
    popped = out_valid && out_ready;
    if (popped) check_pop();
    accepted = iv && in_ready;
    if (accepted) q.push_back(exp_of(v));
  endtask

  task automatic drain();
    logic p;
    logic acc;
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      step(1'b0, tbl[0], 1'b1, 1'b0, p, acc);
    end
    check(q.size() == 0, "drain_empty", q.size(), 0);
  endtask

  initial begin
    logic p;
    logic acc;
    int   lat;
    int   nacc;
    bit   found;

    tbl[0]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    tbl[1]  = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
    tbl[2]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    tbl[3]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 16'h5555, 1'b0, 1'b0};
    tbl[4]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    tbl[5]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
    tbl[6]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
    tbl[7]  = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    tbl[8]  = '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0};
    tbl[9]  = '{16'h00F0, 16'h0F10, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0};
    tbl[10] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    tbl[11] = '{16'h5A5A, 16'hA5A5, 1'b1, 16'hB4B5, 16'h7FFF, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    m = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check(out_valid === 1'b0, "reset_out_valid", out_valid, 0);
    check(w === 16'h0000, "reset_w", w, 0);
    check(c_out === 1'b0 && ov_flag === 1'b0, "reset_flags",
          {c_out, ov_flag}, 0);
    check(in_ready === 1'b1, "reset_in_ready", in_ready, 1);
    rst = 1'b0;

    // latency of a single op on an idle pipe
    step(1'b1, tbl[0], 1'b1, 1'b0, p, acc);
    check(acc === 1'b1, "lat_accept", acc, 1);
    lat = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, tbl[0], 1'b1, 1'b0, p, acc);
      lat++;
      if (p) found = 1;
    end
    check(found && lat == 4, "latency", lat, 4);

    // back-to-back table vectors, full throughput
    pop_cnt = 0;
    nacc = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i], 1'b1, 1'b0, p, acc);
      if (acc) nacc++;
    end
    drain();
    check(nacc == 12, "burst_accepts", nacc, 12);
    check(pop_cnt == 12, "burst_pops", pop_cnt, 12);
    check(last_pop - first_pop == 11, "burst_span",
          last_pop - first_pop, 11);

    // fill then stall for five cycles
    nacc = 0;
    stall_seen = 0;
    for (int i = 0; i < 40 && stall_seen < 5; i++) begin
      step(1'b1, tbl[i % 12], 1'b0, 1'b1, p, acc);
      if (acc) nacc++;
    end
    check(stall_seen == 5, "stall_cycles", stall_seen, 5);
    check(nacc == 4, "fill_accepts", nacc, 4);
    drain();

    // reset with three ops in flight
    for (int i = 4; i < 7; i++) begin
      step(1'b1, tbl[i], 1'b1, 1'b0, p, acc);
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check(in_ready === 1'b1, "rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check(out_valid === 1'b0, "rst_out_valid", out_valid, 0);
    check(w === 16'h0000, "rst_w", w, 0);
    check(c_out === 1'b0 && ov_flag === 1'b0, "rst_flags",
          {c_out, ov_flag}, 0);
    q.delete();
    pop_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, tbl[0], 1'b1, 1'b0, p, acc);
    end
    check(pop_cnt == 0, "rst_no_stale", pop_cnt, 0);

    step(1'b1, tbl[2], 1'b1, 1'b0, p, acc);
    drain();
    check(pop_cnt == 1, "post_rst_op", pop_cnt, 1);

    for (int i = 0; i < 30000 && sw_done != 3; i++) begin
      @(posedge clk);
    end
    check(sw_done == 3, "sweep_finish", sw_done, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  for (genvar s = 0; s < 3; s++) begin : g_sweep
    localparam int W = (s == 2) ? 32 : 8;
    localparam int C = (s == 0) ? 2 : ((s == 1) ? 8 : 4);

    typedef struct packed {
      logic [W-1:0] w;
      logic         c;
      logic         ov;
    } sres_t;

    logic         srst;
    logic         siv;
    logic         sir;
    logic [W-1:0] sa;
    logic [W-1:0] sb;
    logic         sm;
    logic         sov;
    logic         sor;
    logic [W-1:0] sw;
    logic         sc;
    logic         sovf;
    sres_t        sq[$];

    addsub_pipe #(
      .WIDTH(W),
      .CHUNK(C)
    ) u_dut (
      .clk       (clk),
      .rst       (srst),
      .in_valid  (siv),
      .in_ready  (sir),
      .a         (sa),
      .b         (sb),
      .m         (sm),
      .out_valid (sov),
      .out_ready (sor),
      .w         (sw),
      .c_out     (sc),
      .ov_flag   (sovf)
    );

    function automatic sres_t smodel(input logic [W-1:0] x,
                                     input logic [W-1:0] y,
                                     input logic mm);
      logic [W:0]   t;
      logic [W-1:0] yb;
      sres_t        r;
      yb = mm ? ~y : y;
      t = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, mm};
      r.w = t[W-1:0];
      r.c = t[W];
      r.ov = (x[W-1] == yb[W-1]) && (t[W-1] != x[W-1]);
`ifdef ADDSUB_PIPE_SATURATE_EN
      if (r.ov) r.w = x[W-1] ? {1'b1, {(W-1){1'b0}}}
                             : {1'b0, {(W-1){1'b1}}};
`endif
      return r;
    endfunction

    function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
        0:       v = {1'b0, {(W-1){1'b1}}};
        1:       v = {1'b1, {(W-1){1'b0}}};
        2:       v = '1;
        default: v = W'($urandom);
      endcase
      return v;
    endfunction

    task automatic spop();
      sres_t e;
      n_cmp++;
      if (sq.size() == 0) begin
        n_bad++;
        $display("FAIL sweep%0d stale: w=%h", s, sw);
      end else begin
        e = sq.pop_front();
        if (sw !== e.w || sc !== e.c || sovf !== e.ov) begin
          n_bad++;
          $display("FAIL sweep%0d result: got w=%h c=%b ov=%b, want w=%h c=%b ov=%b",
                   s, sw, sc, sovf, e.w, e.c, e.ov);
        end
      end
    endtask

    initial begin
      int acc_n;
      acc_n = 0;
      srst = 1'b1;
      siv = 1'b0;
      sa = '0;
      sb = '0;
      sm = 1'b0;
      sor = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      srst = 1'b0;
      for (int i = 0; i < 20000 && acc_n < 1000; i++) begin
        @(negedge clk);
        siv = ($urandom_range(0, 3) != 0);
        sa  = pick();
        sb  = pick();
        sm  = 1'($urandom);
        sor = ($urandom_range(0, 3) != 0);
        #1;
        if (sov && sor) spop();
        if (siv && sir) begin
          sq.push_back(smodel(sa, sb, sm));
          acc_n++;
        end
      end
      for (int i = 0; i < 100 && sq.size() != 0; i++) begin
        @(negedge clk);
        siv = 1'b0;
        sor = 1'b1;
        #1;
        if (sov) spop();
      end
      n_cmp++;
      if (sq.size() != 0 || acc_n != 1000) begin
        n_bad++;
        $display("FAIL sweep%0d drain: accepted=%0d pending=%0d, want 1000/0",
                 s, acc_n, sq.size());
      end
      sw_done++;
    end
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake on both sides. It generalises the team's fixed 8-bit combinational add/sub to WIDTH bits. The carry chain is split into CHUNK-bit slices, with one register stage per slice, so throughput is one operation per clock at any width. It sits between operand-producing datapath blocks and downstream accumulators/ALU muxes.

Parameters:
WIDTH, 16, operand/result width in bits; must be ≥2 and a multiple of CHUNK.
CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (STAGES=1 is legal).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands present
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A, two's complement
b  input  WIDTH  operand B, two's complement
m  input  1  mode: 0 = a+b, 1 = a-b (b inverted, carry-in = 1)
out_valid  output  1  result present
out_ready  input  1  consumer accepts result this cycle
w  output  WIDTH  result
c_out  output  1  carry out of MSB (for subtraction, 1 = no borrow)
ov_flag  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset: all stage-valid bits are cleared, and out_valid=0, w=0, c_out=0, ov_flag=0 on the cycle after rst is sampled high. rst has priority over all other inputs. A reset mid-operation discards all in-flight operations with no partial output.
- Handshake: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready, and in_ready = adv (combinational, including while in rst).
- Stall: when adv=0, every stage register holds. w, c_out and ov_flag remain stable while out_valid=1 && !out_ready.
- Latency: an operation accepted in cycle t appears with out_valid=1 in cycle t+STAGES, provided no stall occurs. Each stall cycle adds one.
- Throughput: one operation per cycle. No bubbles are inserted.
- Stage k (k=0..STAGES-1) adds slice k of a and of b^{WIDTH{m}} with the carry from stage k-1; stage 0 takes carry m.
  - Stage k registers its CHUNK result bits, its carry out, and the carry into its top bit (needed for ov_flag only in the last stage).
  - Unconsumed upper operand slices and already-resolved lower result slices travel in skew registers.
- A bubble (in_valid=0 while adv=1) propagates as a stage-valid of 0. Data registers of invalid stages may hold anything, but outputs are qualified only by out_valid.
- Simultaneous output pop and input push with a full pipe is legal and keeps full throughput.
- Arithmetic is modulo 2^WIDTH. ov_flag and c_out are computed exactly as defined in Ports and are independent of each other.

Optional Feature:
Macro ADDSUB_PIPE_SATURATE_EN.
- Defined: when ov_flag=1, w is clamped to the signed extreme: 0 followed by WIDTH-1 ones if a's MSB=0, else 1 followed by WIDTH-1 zeros. ov_flag and c_out still report the raw overflow and carry. The clamp is applied at the final register, with no added latency.
- Undefined: w is the wrapped result. No clamp logic is generated.

Decomposition:
- Shared package addsub_pkg:
  - mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1;
  - function computing STAGES from WIDTH/CHUNK;
  - elaboration-time check macro/assertion for WIDTH % CHUNK == 0.
- One natural sub-module, addsub_slice: a CHUNK-bit carry-lookahead adder with inputs x, y, cin and outputs sum, cout, c_msb_in. It is combinational and instantiated once per stage inside a generate loop.

Test Plan:
- WIDTH=16, CHUNK=4; a=0x7FFF, b=0x0001, m=0 -> w=0x8000, c_out=0, ov_flag=1, out_valid exactly 4 cycles after accept. With ADDSUB_PIPE_SATURATE_EN: w=0x7FFF, ov_flag=1.
- a=0x0005, b=0x0007, m=1 -> w=0xFFFE, c_out=0, ov_flag=0. a=0x8000, b=0x0001, m=1 -> w=0x7FFF, c_out=1, ov_flag=1; saturated w=0x8000.
- 8 back-to-back ops with out_ready=1 -> 8 consecutive out_valid cycles in input order with results matching the reference model. Throughput is 1/cycle.
- Fill the pipe, hold out_ready=0 for 5 cycles -> in_ready=0, outputs frozen, nothing lost. Release -> all pending results drain in order.
- Assert rst for 1 cycle with 3 ops in flight -> out_valid=0, w=0, ov_flag=0, c_out=0 next cycle. No stale result ever appears afterwards.
- Parameter sweep (8/2, 8/8, 32/4) with 1000 random ops each, random in_valid/out_ready -> every result matches the model for w, c_out and ov_flag.
